booth_pp_gen: RTL
=================

# booth_pp_gen

Two-stage pipelined radix-4 Booth partial-product generator for 16x16 multiplies, signed or unsigned per transaction. It produces the nine 32-bit partial products P0..P8 consumed by the 9-input Wallace reduction tree (two 4:2 rows plus a 3:2 row). The modulo-2^32 sum of P0..P8 equals the exact 32-bit product. It has a valid/ready handshake on both sides, accepts one operation per cycle and has a latency of 2 cycles.

## Interface
- OP_W, 16, operand width; fixed at 16, other values unsupported
- WIDTH, 32, partial-product width (= 2*OP_W); matches the tree's `width`
- NPP, 9, number of partial products (= OP_W/2 + 1); fixed
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a, b, is_signed valid
- in_ready  out  1  block accepts operands this cycle
- a  in  OP_W  multiplicand
- b  in  OP_W  multiplier (Booth-recoded)
- is_signed  in  1  1: both operands two's complement; 0: both unsigned
- out_valid  out  1  P0..P8 valid
- out_ready  in  1  downstream consumes P0..P8 this cycle
- P0..P8  out  WIDTH each  partial products, row i weighted by 4^i (shift already applied)

## Operation
- Transfer on either side occurs when valid && ready in the same cycle.
- Stage 1 (S1) registers on input transfer:
  - A_ext: 32-bit extension of a; sign-extend if is_signed, zero-extend otherwise.
  - Nine 3-bit Booth groups from b_ext[17:-1], where b_ext = {2{b[15]&is_signed}, b} and b_ext[-1] = 0.
  - Group i = {b_ext[2i+1], b_ext[2i], b_ext[2i-1]}.
- Stage 2 (S2) forms PPi = (digit_i * A_ext) << 2i, truncated to 32 bits, full two's complement with no sign-encoding tricks and no separate +1 row. Digit decode:
  - 000, 111 → 0
  - 001, 010 → +1
  - 011 → +2
  - 100 → −2
  - 101, 110 → −1
  - Negative digits use the complement plus 1 applied inside the same row.
- Signed mode: group 8 is always 000, so P8 = 0. Unsigned mode: P8 = A_ext<<16 when b[15] = 1, else 0.
- Invariant: (P0 + … + P8) mod 2^32 = a*b, interpreted signed or unsigned per is_signed.
- Pipeline control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- Outputs P0..P8 and out_valid come directly from S2 registers.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = 0, s2_valid = 0, all S1 data and P0..P8 = 0, out_valid = 0. in_ready = 1 once reset is released.
- Latency: an operand accepted in cycle n gives out_valid = 1 in cycle n+2 if out_ready stays high.
- Throughput: 1 transaction/cycle with out_ready high. Back-to-back transfers must not drop or duplicate data.
- Stall: while out_valid && !out_ready, P0..P8 and out_valid hold stable.
  - S1 fills, then in_ready drops.
  - At most 2 transactions are held internally.
- Simultaneous fill and drain: when S2 is consumed and S1 is full in the same cycle, S1 moves to S2, and S1 may accept a new input in that same cycle.
- Bubble: when S1 is empty and S2 advances, s2_valid clears; P0..P8 may keep stale values while out_valid = 0.
- Reset mid-operation discards all in-flight transactions. Nothing is emitted after release until new input.
- is_signed is sampled with a and b and travels with its transaction. Mixing modes on consecutive cycles is legal.

## Test plan
- Unsigned a=0x0005, b=0x0003 → after 2 cycles P0=0xFFFFFFFB, P1=0x00000014, P2..P8=0; sum 0x0000000F.
- Unsigned a=b=0xFFFF → sum(P0..P8) mod 2^32 = 0xFFFE0001; P8 = 0xFFFF0000. Signed a=b=0x8000 → sum = 0x40000000, P8 = 0.
- Signed a=0xFFFF (−1), b=0x0001 → sum = 0xFFFFFFFF. Alternating is_signed per cycle with same a=b=0xFFFF → outputs alternate 0xFFFE0001 / 0x00000001.
- Backpressure: out_ready=0, drive 3 valid inputs → first two accepted, in_ready=0 on third. Raise out_ready → results emerge in order, one per cycle, none lost.
- Throughput/reference: 10k random a, b, is_signed with random out_ready → every sum matches the golden product, in order. Same outputs fed through the 9-input tree: sum + (carry<<1) equals the product.
- Reset asserted with 2 transactions in flight → out_valid=0 and P0..P8=0 immediately (asynchronous). After release, no stale output appears.

Source files
------------

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator for 16x16 signed/unsigned multiplies.
// S1 registers the extended multiplicand and Booth groups; S2 registers the nine weighted rows.
module booth_pp_gen #(
    parameter int OP_W  = 16,
    parameter int WIDTH = 2 * OP_W,
    parameter int NPP   = OP_W / 2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P0,
    output logic [WIDTH-1:0] P1,
    output logic [WIDTH-1:0] P2,
    output logic [WIDTH-1:0] P3,
    output logic [WIDTH-1:0] P4,
    output logic [WIDTH-1:0] P5,
    output logic [WIDTH-1:0] P6,
    output logic [WIDTH-1:0] P7,
    output logic [WIDTH-1:0] P8
);

    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s1_adv;
    logic                        s2_adv;
    logic [WIDTH-1:0]            s1_a_ext;
    logic [NPP-1:0][2:0]         s1_grp;
    logic [NPP-1:0][2:0]         grp_d;
    logic [NPP-1:0][WIDTH-1:0]   pp_d;
    logic [NPP-1:0][WIDTH-1:0]   pp_q;
    logic [WIDTH-1:0]            a_ext_d;
    logic [OP_W+2:0]             b_ext;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign a_ext_d = {{(WIDTH - OP_W){a[OP_W-1] & is_signed}}, a};
    // Two extension bits on top, implicit zero below bit 0.
    assign b_ext   = {{2{b[OP_W-1] & is_signed}}, b, 1'b0};

    always_comb begin
        grp_d = '0;
        for (int i = 0; i < NPP; i++) begin
            grp_d[i] = b_ext[2*i +: 3];
        end
    end

    function automatic logic [WIDTH-1:0] booth_row(input logic [2:0] grp,
                                                   input logic [WIDTH-1:0] a_x);
        logic [WIDTH-1:0] mag;
        logic             neg;
        mag = '0;
        neg = 1'b0;
        case (grp)
            3'b001, 3'b010: mag = a_x;
            3'b011:         mag = a_x << 1;
            3'b100: begin
                mag = a_x << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = a_x;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
        return neg ? (~mag + WIDTH'(1)) : mag;
    endfunction

    always_comb begin
        pp_d = '0;
        for (int i = 0; i < NPP; i++) begin
            pp_d[i] = booth_row(s1_grp[i], s1_a_ext) << (2 * i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a_ext <= '0;
            s1_grp   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a_ext <= a_ext_d;
                s1_grp   <= grp_d;
            end
        end
    end

    // Rows keep stale values across bubbles; only out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            pp_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                pp_q <= pp_d;
            end
        end
    end

    assign out_valid = s2_valid;
    assign P0 = pp_q[0];
    assign P1 = pp_q[1];
    assign P2 = pp_q[2];
    assign P3 = pp_q[3];
    assign P4 = pp_q[4];
    assign P5 = pp_q[5];
    assign P6 = pp_q[6];
    assign P7 = pp_q[7];
    assign P8 = pp_q[8];

endmodule
